// File: rtl/uart_reg_bridge_if.sv
// uart_reg_bridge_if: UART byte streams plus single-byte register bus around the bridge.
interface uart_reg_bridge_if #(
   parameter int ADDR_W = 7
);
   logic [7:0] rx_data;
   logic rx_valid;
   logic [7:0] tx_data;
   logic tx_valid;
   logic tx_ready;
   logic [ADDR_W-1:0] reg_addr;
   logic [7:0] reg_wdata;
   logic reg_we;
   logic reg_re;
   logic [7:0] reg_rdata;
   logic overrun;
   logic timeout;
   modport master (
      output rx_data, rx_valid, tx_ready, reg_rdata,
      input tx_data, tx_valid, reg_addr, reg_wdata, reg_we, reg_re, overrun, timeout
   );
   modport slave (
      input rx_data, rx_valid, tx_ready, reg_rdata,
      output tx_data, tx_valid, reg_addr, reg_wdata, reg_we, reg_re, overrun, timeout
   );
endinterface

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: decodes host command frames into single-byte register writes/reads,
// returns read data to the UART transmitter and abandons truncated write frames.
module uart_reg_bridge #(
   parameter int ADDR_W = 7,
   parameter int TIMEOUT_CYC = 100000
) (
   input logic clk,
   input logic n_reset,
   uart_reg_bridge_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT_CYC);
   typedef enum logic [2:0] {IDLE, WAIT_DATA, WRITE, READ_REQ, READ_CAP, SEND} state_t;
   state_t state, nxt;
   logic [CW-1:0] cnt;
   logic tmo;
   logic busy;
   logic [ADDR_W-1:0] addr;
   logic [7:0] wdata;
   logic [7:0] tdata;
   logic ovr;
   assign busy = state inside {WRITE, READ_REQ, READ_CAP, SEND};
   // a data byte on the terminal-count cycle still completes the frame
   always_comb begin
      nxt = state;
      tmo = 1'b0;
      case (state)
         IDLE: nxt = bus.rx_valid ? (bus.rx_data[7] ? WAIT_DATA : READ_REQ) : IDLE;
         WAIT_DATA: begin
            tmo = !bus.rx_valid && cnt == CW'(TIMEOUT_CYC - 1);
            nxt = bus.rx_valid ? WRITE : (tmo ? IDLE : WAIT_DATA);
         end
         WRITE: nxt = IDLE;
         READ_REQ: nxt = READ_CAP;
         READ_CAP: nxt = SEND;
         SEND: nxt = bus.tx_ready ? IDLE : SEND;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state <= IDLE;
         cnt <= '0;
         addr <= '0;
         wdata <= '0;
         tdata <= '0;
         ovr <= 1'b0;
      end else begin
         state <= nxt;
         cnt <= (state == WAIT_DATA && !bus.rx_valid && !tmo) ? cnt + CW'(1) : '0;
         if (state == IDLE && bus.rx_valid) addr <= bus.rx_data[ADDR_W-1:0];
         if (state == WAIT_DATA && bus.rx_valid) wdata <= bus.rx_data;
         if (state == READ_CAP) tdata <= bus.reg_rdata;
         if (busy && bus.rx_valid) ovr <= 1'b1;
      end
   end
   assign bus.reg_addr = addr;
   assign bus.reg_wdata = wdata;
   assign bus.reg_we = state == WRITE;
   assign bus.reg_re = state == READ_REQ;
   assign bus.tx_data = tdata;
   assign bus.tx_valid = state == SEND;
   assign bus.overrun = ovr;
   assign bus.timeout = tmo;
endmodule

// File: tb/tb_uart_reg_bridge.sv
// tb_uart_reg_bridge: scoreboard bench driving command frames against a small register-file model.
module tb_uart_reg_bridge;
   logic clk = 1'b0;
   logic n_reset = 1'b0;
   always #5 clk = ~clk;
   uart_reg_bridge_if #(.ADDR_W(7)) bus ();
   uart_reg_bridge #(.ADDR_W(7), .TIMEOUT_CYC(16)) dut (.clk(clk), .n_reset(n_reset), .bus(bus));
   int pass_cnt = 0, total = 0;
   int wr_seen = 0, rd_seen = 0, tx_seen = 0, tmo_seen = 0;
   logic [14:0] exp_wr [$];
   logic [6:0] exp_rd [$];
   logic [7:0] exp_tx [$];
   logic [14:0] ew;
   logic [6:0] er;
   logic [7:0] et;
   logic [7:0] mem [128];
   logic [7:0] pt [8];
   logic [7:0] key [12];
   // register file: start register at 0x18 fills ciphertext 0x20..0x27
   always @(posedge clk) begin
      if (bus.reg_re) bus.reg_rdata <= mem[bus.reg_addr];
      if (bus.reg_we) begin
         mem[bus.reg_addr] <= bus.reg_wdata;
         if (bus.reg_addr == 7'h18)
            for (int i = 0; i < 8; i++) mem[7'(32 + i)] <= (mem[7'(i)] ^ mem[7'(8 + i)]) + mem[7'(12 + i)];
      end
   end
   always begin
      @(negedge clk);
      #1;
      if (bus.reg_we && bus.reg_re) begin
         total++;
         $display("FAIL we_re_overlap reg_we=1 reg_re=1 exp never both");
      end
      if (bus.reg_we) begin
         wr_seen++;
         total++;
         if (exp_wr.size() == 0) $display("FAIL wr_unexpected addr=%h data=%h exp no write", bus.reg_addr, bus.reg_wdata);
         else begin
            ew = exp_wr.pop_front();
            if ({bus.reg_addr, bus.reg_wdata} !== ew) $display("FAIL wr got %h/%h exp %h/%h", bus.reg_addr, bus.reg_wdata, ew[14:8], ew[7:0]);
            else pass_cnt++;
         end
      end
      if (bus.reg_re) begin
         rd_seen++;
         total++;
         if (exp_rd.size() == 0) $display("FAIL rd_unexpected addr=%h exp no read", bus.reg_addr);
         else begin
            er = exp_rd.pop_front();
            if (bus.reg_addr !== er) $display("FAIL rd_addr got %h exp %h", bus.reg_addr, er);
            else pass_cnt++;
         end
      end
      if (bus.tx_valid && bus.tx_ready) begin
         tx_seen++;
         total++;
         if (exp_tx.size() == 0) $display("FAIL tx_unexpected data=%h exp no byte", bus.tx_data);
         else begin
            et = exp_tx.pop_front();
            if (bus.tx_data !== et) $display("FAIL tx_data got %h exp %h", bus.tx_data, et);
            else pass_cnt++;
         end
      end
      if (bus.timeout) tmo_seen++;
   end
   task automatic send_byte(input logic [7:0] b);
      bus.rx_data = b;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask
   task automatic do_write(input logic [6:0] a, input logic [7:0] d);
      exp_wr.push_back({a, d});
      send_byte({1'b1, a});
      send_byte(d);
      @(negedge clk);
   endtask
   task automatic do_read(input logic [6:0] a, input logic [7:0] d);
      int t0 = tx_seen;
      exp_rd.push_back(a);
      exp_tx.push_back(d);
      send_byte({1'b0, a});
      for (int i = 0; i < 20 && tx_seen == t0; i++) @(negedge clk);
      total++;
      if (tx_seen == t0) $display("FAIL read_no_tx addr=%h got none exp %h", a, d); else pass_cnt++;
   endtask
   task automatic test_reset();
      n_reset = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data = 8'h00;
      bus.tx_ready = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({bus.tx_valid, bus.reg_we, bus.reg_re, bus.timeout, bus.overrun, bus.reg_addr, bus.reg_wdata, bus.tx_data} !== 28'h0)
         $display("FAIL reset_outputs got %h exp 0", {bus.tx_valid, bus.reg_we, bus.reg_re, bus.timeout, bus.overrun, bus.reg_addr, bus.reg_wdata, bus.tx_data});
      else pass_cnt++;
      n_reset = 1'b1;
      @(negedge clk);
   endtask
   task automatic test_write();
      int w0 = wr_seen;
      int t0 = tx_seen;
      exp_wr.push_back({7'h00, 8'h63});
      send_byte(8'h80);
      send_byte(8'h63);
      #1;
      total++;
      if (bus.reg_we !== 1'b1) $display("FAIL write_timing reg_we=%b exp 1", bus.reg_we); else pass_cnt++;
      repeat (4) @(negedge clk);
      total++;
      if (wr_seen - w0 != 1) $display("FAIL write_count got %0d exp 1", wr_seen - w0); else pass_cnt++;
      total++;
      if (tx_seen != t0 || bus.tx_valid !== 1'b0) $display("FAIL write_no_tx tx_valid=%b exp 0", bus.tx_valid); else pass_cnt++;
   endtask
   task automatic test_read();
      int t0;
      logic ok = 1'b1;
      do_write(7'h14, 8'hA5);
      t0 = tx_seen;
      exp_rd.push_back(7'h14);
      exp_tx.push_back(8'hA5);
      bus.tx_ready = 1'b0;
      send_byte(8'h14);
      #1;
      total++;
      if (bus.reg_re !== 1'b1) $display("FAIL read_re_timing reg_re=%b exp 1", bus.reg_re); else pass_cnt++;
      @(negedge clk);
      total++;
      if (bus.tx_valid !== 1'b0) $display("FAIL read_early_valid tx_valid=%b exp 0", bus.tx_valid); else pass_cnt++;
      @(negedge clk);
      total++;
      if ({bus.tx_valid, bus.tx_data} !== 9'h1A5) $display("FAIL read_valid got %b/%h exp 1/a5", bus.tx_valid, bus.tx_data); else pass_cnt++;
      for (int i = 0; i < 10; i++) begin
         if ({bus.tx_valid, bus.tx_data} !== 9'h1A5) ok = 1'b0;
         @(negedge clk);
      end
      total++;
      if (!ok) $display("FAIL read_hold got unstable exp 1/a5 held"); else pass_cnt++;
      bus.tx_ready = 1'b1;
      @(negedge clk);
      bus.tx_ready = 1'b0;
      total++;
      if (bus.tx_valid !== 1'b0 || tx_seen != t0 + 1) $display("FAIL read_release tx_valid=%b bytes=%0d exp 0/1", bus.tx_valid, tx_seen - t0); else pass_cnt++;
   endtask
   task automatic test_simon();
      int w0 = wr_seen;
      int r0 = rd_seen;
      int t0 = tx_seen;
      for (int i = 0; i < 8; i++) begin
         pt[i] = 8'($urandom);
         do_write(7'(i), pt[i]);
      end
      for (int i = 0; i < 12; i++) begin
         key[i] = 8'($urandom);
         do_write(7'(8 + i), key[i]);
      end
      do_write(7'h18, 8'h01);
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) do_read(7'(32 + i), (pt[i] ^ key[i]) + key[i + 4]);
      bus.tx_ready = 1'b0;
      @(negedge clk);
      total++;
      if ((wr_seen - w0) + (rd_seen - r0) != 29) $display("FAIL simon_strobes got %0d exp 29", (wr_seen - w0) + (rd_seen - r0)); else pass_cnt++;
      total++;
      if (tx_seen - t0 != 8) $display("FAIL simon_tx got %0d exp 8", tx_seen - t0); else pass_cnt++;
   endtask
   task automatic test_timeout();
      int w0 = wr_seen;
      int m0 = tmo_seen;
      int k = 1;
      send_byte(8'h85);
      for (k = 1; k <= 40; k++) begin
         #1;
         if (bus.timeout) break;
         @(negedge clk);
      end
      total++;
      if (k != 16) $display("FAIL timeout_latency got %0d exp 16", k); else pass_cnt++;
      @(negedge clk);
      total++;
      if (wr_seen != w0 || tmo_seen != m0 + 1) $display("FAIL timeout_effects writes=%0d pulses=%0d exp 0/1", wr_seen - w0, tmo_seen - m0); else pass_cnt++;
      do_write(7'h05, 8'h11);
      total++;
      if (wr_seen != w0 + 1) $display("FAIL timeout_recover writes=%0d exp 1", wr_seen - w0); else pass_cnt++;
      exp_wr.push_back({7'h05, 8'h22});
      send_byte(8'h85);
      repeat (15) @(negedge clk);
      bus.rx_data = 8'h22;
      bus.rx_valid = 1'b1;
      #1;
      total++;
      if (bus.timeout !== 1'b0) $display("FAIL tie_timeout timeout=%b exp 0", bus.timeout); else pass_cnt++;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      total++;
      if (bus.reg_we !== 1'b1) $display("FAIL tie_write reg_we=%b exp 1", bus.reg_we); else pass_cnt++;
      repeat (20) @(negedge clk);
      total++;
      if (tmo_seen != m0 + 1 || wr_seen != w0 + 2) $display("FAIL tie_effects pulses=%0d writes=%0d exp 1/2", tmo_seen - m0, wr_seen - w0); else pass_cnt++;
   endtask
   task automatic test_overrun();
      int r0 = rd_seen;
      int t0 = tx_seen;
      bus.tx_ready = 1'b0;
      exp_rd.push_back(7'h02);
      exp_tx.push_back(pt[2]);
      total++;
      if (bus.overrun !== 1'b0) $display("FAIL overrun_pre overrun=%b exp 0", bus.overrun); else pass_cnt++;
      send_byte(8'h02);
      for (int i = 0; i < 10 && !bus.tx_valid; i++) @(negedge clk);
      send_byte(8'h99);
      total++;
      if ({bus.overrun, bus.tx_valid, bus.tx_data} !== {2'b11, pt[2]}) $display("FAIL overrun_set got %b/%b/%h exp 1/1/%h", bus.overrun, bus.tx_valid, bus.tx_data, pt[2]); else pass_cnt++;
      bus.tx_ready = 1'b1;
      @(negedge clk);
      bus.tx_ready = 1'b0;
      @(negedge clk);
      total++;
      if (tx_seen != t0 + 1 || rd_seen != r0 + 1 || bus.overrun !== 1'b1) $display("FAIL overrun_deliver bytes=%0d reads=%0d overrun=%b exp 1/1/1", tx_seen - t0, rd_seen - r0, bus.overrun); else pass_cnt++;
      n_reset = 1'b0;
      #1;
      total++;
      if (bus.overrun !== 1'b0) $display("FAIL overrun_clear overrun=%b exp 0", bus.overrun); else pass_cnt++;
      @(negedge clk);
      n_reset = 1'b1;
      @(negedge clk);
   endtask
   task automatic test_reset_mid();
      int w0 = wr_seen;
      int m0 = tmo_seen;
      int t0 = tx_seen;
      send_byte(8'h85);
      n_reset = 1'b0;
      #1;
      total++;
      if ({bus.tx_valid, bus.reg_we, bus.reg_re, bus.timeout, bus.overrun, bus.reg_addr, bus.reg_wdata, bus.tx_data} !== 28'h0)
         $display("FAIL reset_wait_data got %h exp 0", {bus.tx_valid, bus.reg_we, bus.reg_re, bus.timeout, bus.overrun, bus.reg_addr, bus.reg_wdata, bus.tx_data});
      else pass_cnt++;
      @(negedge clk);
      n_reset = 1'b1;
      repeat (20) @(negedge clk);
      total++;
      if (wr_seen != w0 || tmo_seen != m0) $display("FAIL reset_wait_after writes=%0d pulses=%0d exp 0/0", wr_seen - w0, tmo_seen - m0); else pass_cnt++;
      bus.tx_ready = 1'b0;
      exp_rd.push_back(7'h14);
      send_byte(8'h14);
      for (int i = 0; i < 10 && !bus.tx_valid; i++) @(negedge clk);
      total++;
      if (bus.tx_valid !== 1'b1) $display("FAIL reset_send_pre tx_valid=%b exp 1", bus.tx_valid); else pass_cnt++;
      n_reset = 1'b0;
      #1;
      total++;
      if ({bus.tx_valid, bus.tx_data} !== 9'h0) $display("FAIL reset_send got %b/%h exp 0/00", bus.tx_valid, bus.tx_data); else pass_cnt++;
      @(negedge clk);
      n_reset = 1'b1;
      bus.tx_ready = 1'b1;
      repeat (10) @(negedge clk);
      bus.tx_ready = 1'b0;
      total++;
      if (tx_seen != t0 || bus.tx_valid !== 1'b0 || wr_seen != w0) $display("FAIL reset_send_after bytes=%0d tx_valid=%b exp 0/0", tx_seen - t0, bus.tx_valid); else pass_cnt++;
   endtask
   initial begin
      test_reset();
      test_write();
      test_read();
      test_simon();
      test_timeout();
      test_overrun();
      test_reset_mid();
      total++;
      if (exp_wr.size() + exp_rd.size() + exp_tx.size() != 0) $display("FAIL scoreboard_left got %0d/%0d/%0d exp 0/0/0", exp_wr.size(), exp_rd.size(), exp_tx.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog got no finish exp finish");
      $fatal(1);
   end
endmodule

// File: doc/uart_reg_bridge.md
# uart_reg_bridge

Byte-level command decoder between the UART receiver/transmitter and the register file of the Simon cipher top (plaintext, key, start, ciphertext registers). Parses host command frames from the received byte stream, issues single-byte register writes and reads, and returns read data to the UART transmitter. Includes an inter-byte timeout so that a truncated frame cannot lock the bridge.

## Interface
- ADDR_W, 7: register address width; command byte bits [ADDR_W-1:0].
- TIMEOUT_CYC, 100000: max clk cycles between command byte and data byte of a write frame; must be ≥ 2.
- clk  in  1  system clock; all logic on rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- tx_data  out  8  byte to UART transmitter.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  transmitter accepts tx_data when tx_valid && tx_ready.
- reg_addr  out  ADDR_W  register address.
- reg_wdata  out  8  register write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  8  read data, valid exactly 1 cycle after reg_re.
- overrun  out  1  sticky: a byte arrived while busy and was dropped.
- timeout  out  1  one-cycle pulse when a write frame is abandoned.

## Operation
- Frame format: command byte C, bit 7 = 1 write / 0 read, C[ADDR_W-1:0] = address; bits between ADDR_W and 6 ignored. A write frame is C followed by one data byte; a read frame is C alone.
- States: IDLE, WAIT_DATA, WRITE, READ_REQ, READ_CAP, SEND.
- IDLE: on rx_valid latch address; C[7]=1 → WAIT_DATA (timeout counter cleared); C[7]=0 → READ_REQ.
- WAIT_DATA: on rx_valid latch reg_wdata → WRITE. Counter increments each cycle without rx_valid; reaching TIMEOUT_CYC-1 with no byte → pulse timeout, → IDLE, address discarded. rx_valid on the same cycle as the timeout terminal count wins (byte accepted, no timeout).
- WRITE: reg_we=1 for one cycle → IDLE.
- READ_REQ: reg_re=1 for one cycle → READ_CAP.
- READ_CAP: capture reg_rdata into tx_data → SEND.
- SEND: tx_valid=1; on tx_ready → IDLE, tx_valid drops the next cycle.
- Bytes received in WRITE, READ_REQ, READ_CAP, SEND: dropped, overrun set to 1 (cleared only by reset). Bridge state is not disturbed.
- reg_addr and reg_wdata hold their last latched values outside strobes; reg_we and reg_re are never asserted together.
- No address range check: unmapped addresses are passed through; the register file defines their behaviour.

## Timing
- Reset (asynchronous assert): state IDLE; tx_data=0, tx_valid=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, overrun=0, timeout=0, counter=0. Deassertion is synchronised upstream; first byte accepted on the first edge with n_reset high.
- Write: data byte strobe at edge N → reg_we high in cycle N+1 with reg_addr/reg_wdata stable.
- Read: command strobe at edge N → reg_re in cycle N+1, reg_rdata sampled at edge N+2, tx_valid high from cycle N+3.
- Minimum back-to-back: next command byte accepted in the cycle after reg_we (write) or after the tx handshake (read).
- Reset mid-frame: frame lost, no strobe or tx byte emitted after reset, tx_valid drops immediately.
- tx_data stable while tx_valid=1 and tx_ready=0.

## Test plan
- Write: bytes 0x80, 0x63 → single reg_we with reg_addr=0x00, reg_wdata=0x63, one cycle after second strobe; no tx byte.
- Read: byte 0x14, reg_rdata=0xA5 in the cycle after reg_re → reg_re at addr 0x14, tx_data=0xA5 held with tx_ready low 10 cycles, then released on tx_ready.
- Full Simon sequence: 8 plaintext + 12 key writes, start write, 8 ciphertext reads against a register model → 29 strobes in order, 8 tx bytes matching the model.
- Timeout with TIMEOUT_CYC=16: byte 0x85, then silence → timeout pulse 16 cycles later, no reg_we; following 0x85,0x11 performs a normal write.
- Overrun: byte 0x02 then a second byte while in SEND → second byte ignored, overrun=1, tx byte still delivered; reset clears overrun.
- Reset asserted in WAIT_DATA and in SEND → outputs at reset values immediately, no strobe after release.
